// File: rtl/kv_dcache.sv
// N-way set-associative write-back, write-allocate data cache with byte-strobed stores.
// One request in flight; a miss evicts a victim (writing it back if dirty), fills, then replays the lookup.
module kv_dcache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WAY_NUM    = 2,
    parameter int LINE_SIZE  = 4,
    parameter int LINE_NUM   = 64
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    output logic [DATA_WIDTH-1:0]                o_load_data,
    output logic                                 o_load_valid,
    input  logic                                 i_load_ready,
    input  logic [ADDR_WIDTH-1:0]                i_load_addr,
    input  logic                                 i_load_valid,
    output logic                                 o_load_ready,
    input  logic [DATA_WIDTH-1:0]                i_store_data,
    input  logic [DATA_WIDTH/8-1:0]              i_store_strb,
    input  logic [ADDR_WIDTH-1:0]                i_store_addr,
    input  logic                                 i_store_valid,
    output logic                                 o_store_ready,
    output logic [ADDR_WIDTH-1:0]                o_fetch_addr,
    output logic                                 o_fetch_valid,
    input  logic                                 i_fetch_ready,
    input  logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] i_fetch_data,
    input  logic                                 i_fetch_valid,
    output logic                                 o_fetch_ready,
    output logic [ADDR_WIDTH-1:0]                o_line_addr,
    output logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] o_line_data,
    output logic                                 o_line_valid,
    input  logic                                 i_line_ready
);
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int OFF_BITS  = $clog2(STRB_W);
    localparam int WORD_BITS = $clog2(LINE_SIZE);
    localparam int IDX_BITS  = $clog2(LINE_NUM);
    localparam int LINE_LSB  = OFF_BITS + WORD_BITS;
    localparam int TAG_LSB   = LINE_LSB + IDX_BITS;
    localparam int TAG_W     = ADDR_WIDTH - TAG_LSB;
    localparam int WORD_W    = (WORD_BITS > 0) ? WORD_BITS : 1;
    localparam int IDX_W     = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int WAY_W     = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_RESPOND, S_WRITEBACK, S_FETCH, S_FILL} state_t;

    state_t r_state, w_state_next;

    logic [TAG_W-1:0]                      r_tag   [LINE_NUM][WAY_NUM];
    logic [LINE_SIZE-1:0][DATA_WIDTH-1:0]  r_data  [LINE_NUM][WAY_NUM];
    logic [WAY_NUM-1:0]                    r_valid [LINE_NUM];
    logic [WAY_NUM-1:0]                    r_dirty [LINE_NUM];
    logic [WAY_W-1:0]                      r_ptr   [LINE_NUM];

    logic [ADDR_WIDTH-1:0] r_addr, r_fetch_addr, r_line_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_load_data;
    logic [STRB_W-1:0]     r_strb;
    logic                  r_is_store;
    logic [WAY_W-1:0]      r_victim;

    logic [WORD_W-1:0]     w_word;
    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [ADDR_WIDTH-1:0] w_line_base, w_victim_addr;
    logic [WAY_NUM-1:0]    w_hit_vec;
    logic                  w_hit, w_accept_load, w_accept_store;
    logic [WAY_W-1:0]      w_hit_way, w_victim;
    logic [DATA_WIDTH-1:0] w_hit_word, w_merged;

    assign w_word      = WORD_W'((r_addr >> OFF_BITS) & ADDR_WIDTH'(LINE_SIZE - 1));
    assign w_idx       = IDX_W'((r_addr >> LINE_LSB) & ADDR_WIDTH'(LINE_NUM - 1));
    assign w_tag       = TAG_W'(r_addr >> TAG_LSB);
    assign w_line_base = r_addr & ~ADDR_WIDTH'((1 << LINE_LSB) - 1);
    assign w_victim_addr = (ADDR_WIDTH'(r_tag[w_idx][w_victim]) << TAG_LSB)
                         | (ADDR_WIDTH'(w_idx) << LINE_LSB);

    genvar gi;
    generate
        for (gi = 0; gi < WAY_NUM; gi++) begin : g_hit
            assign w_hit_vec[gi] = r_valid[w_idx][gi] && (r_tag[w_idx][gi] == w_tag);
        end
        for (gi = 0; gi < STRB_W; gi++) begin : g_merge
            assign w_merged[gi*8 +: 8] = r_strb[gi] ? r_wdata[gi*8 +: 8] : w_hit_word[gi*8 +: 8];
        end
    endgenerate

    // Victim: lowest invalid way if any, otherwise the set's round-robin pointer.
    always_comb begin
        w_hit     = |w_hit_vec;
        w_hit_way = '0;
        w_victim  = r_ptr[w_idx];
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (w_hit_vec[w])
                w_hit_way = WAY_W'(w);
            if (!r_valid[w_idx][w])
                w_victim = WAY_W'(w);
        end
    end

    assign w_hit_word   = r_data[w_idx][w_hit_way][w_word];
    assign o_line_data  = r_data[w_idx][r_victim];
    assign o_load_data  = r_load_data;
    assign o_fetch_addr = r_fetch_addr;
    assign o_line_addr  = r_line_addr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        o_load_ready   = 1'b0;
        o_store_ready  = 1'b0;
        o_load_valid   = 1'b0;
        o_line_valid   = 1'b0;
        o_fetch_valid  = 1'b0;
        o_fetch_ready  = 1'b0;
        w_accept_load  = 1'b0;
        w_accept_store = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_load_ready  = 1'b1;
                o_store_ready = ~i_load_valid;
                if (i_load_valid) begin
                    w_accept_load = 1'b1;
                    w_state_next  = S_LOOKUP;
                end else if (i_store_valid) begin
                    w_accept_store = 1'b1;
                    w_state_next   = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit)
                    w_state_next = r_is_store ? S_IDLE : S_RESPOND;
                else if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                    w_state_next = S_WRITEBACK;
                else
                    w_state_next = S_FETCH;
            end
            S_RESPOND: begin
                o_load_valid = 1'b1;
                if (i_load_ready) w_state_next = S_IDLE;
            end
            S_WRITEBACK: begin
                o_line_valid = 1'b1;
                if (i_line_ready) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                o_fetch_valid = 1'b1;
                if (i_fetch_ready) w_state_next = S_FILL;
            end
            S_FILL: begin
                o_fetch_ready = 1'b1;
                if (i_fetch_valid) w_state_next = S_LOOKUP;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_strb       <= '0;
            r_is_store   <= 1'b0;
            r_victim     <= '0;
            r_load_data  <= '0;
            r_fetch_addr <= '0;
            r_line_addr  <= '0;
            for (int s = 0; s < LINE_NUM; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_ptr[s]   <= '0;
            end
        end else begin
            if (w_accept_load) begin
                r_addr     <= i_load_addr;
                r_is_store <= 1'b0;
            end else if (w_accept_store) begin
                r_addr     <= i_store_addr;
                r_wdata    <= i_store_data;
                r_strb     <= i_store_strb;
                r_is_store <= 1'b1;
            end
            if (r_state == S_LOOKUP) begin
                if (w_hit) begin
                    if (r_is_store)
                        r_dirty[w_idx][w_hit_way] <= 1'b1;
                    else
                        r_load_data <= w_hit_word;
                end else begin
                    r_victim     <= w_victim;
                    r_line_addr  <= w_victim_addr;
                    r_fetch_addr <= w_line_base;
                end
            end
            if (r_state == S_FILL && i_fetch_valid) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= 1'b0;
                r_ptr[w_idx] <= (r_victim == WAY_W'(WAY_NUM - 1)) ? '0 : r_victim + 1'b1;
            end
        end
    end

    // Line payload and tags need no reset: they are ignored while the valid bit is clear.
    always_ff @(posedge i_clk) begin
        if (r_state == S_LOOKUP && w_hit && r_is_store)
            r_data[w_idx][w_hit_way][w_word] <= w_merged;
        if (r_state == S_FILL && i_fetch_valid) begin
            r_data[w_idx][r_victim] <= i_fetch_data;
            r_tag[w_idx][r_victim]  <= w_tag;
        end
    end
endmodule

// File: tb/tb_kv_dcache.sv
// Randomized self-checking bench for kv_dcache: a flat architectural memory plus a
// set/way occupancy model predict load data, writeback/fetch traffic and hit latency.
module tb_kv_dcache;
    localparam int SETS = 64;
    localparam int WAYS = 2;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [31:0]       o_load_data;
    logic              o_load_valid;
    logic              i_load_ready;
    logic [31:0]       i_load_addr;
    logic              i_load_valid;
    logic              o_load_ready;
    logic [31:0]       i_store_data;
    logic [3:0]        i_store_strb;
    logic [31:0]       i_store_addr;
    logic              i_store_valid;
    logic              o_store_ready;
    logic [31:0]       o_fetch_addr;
    logic              o_fetch_valid;
    logic              i_fetch_ready;
    logic [3:0][31:0]  i_fetch_data;
    logic              i_fetch_valid;
    logic              o_fetch_ready;
    logic [31:0]       o_line_addr;
    logic [3:0][31:0]  o_line_data;
    logic              o_line_valid;
    logic              i_line_ready;

    kv_dcache dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_load_data(o_load_data), .o_load_valid(o_load_valid), .i_load_ready(i_load_ready),
        .i_load_addr(i_load_addr), .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
        .i_store_data(i_store_data), .i_store_strb(i_store_strb), .i_store_addr(i_store_addr),
        .i_store_valid(i_store_valid), .o_store_ready(o_store_ready),
        .o_fetch_addr(o_fetch_addr), .o_fetch_valid(o_fetch_valid), .i_fetch_ready(i_fetch_ready),
        .i_fetch_data(i_fetch_data), .i_fetch_valid(i_fetch_valid), .o_fetch_ready(o_fetch_ready),
        .o_line_addr(o_line_addr), .o_line_data(o_line_data), .o_line_valid(o_line_valid),
        .i_line_ready(i_line_ready)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural view (what a load must return) and the memory's own contents.
    logic [31:0] shadow  [int unsigned];
    logic [31:0] backing [int unsigned];

    // Occupancy model: which line sits in which way, its dirtiness, and the per-set pointer.
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    logic [21:0] m_tag   [SETS][WAYS];
    int          m_ptr   [SETS];

    int          wait_cnt, bp_fixed = -1;
    int          wb_cnt, fetch_cnt, exp_wb_cur;
    bit          wb_open, fetch_open;
    logic [31:0] wb_addr_seen, fetch_addr_seen, hold_addr;
    logic [31:0] hold_w1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input int unsigned k);
        return k * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        int unsigned k = a >> 2;
        return shadow.exists(k) ? shadow[k] : dflt(k);
    endfunction

    function automatic logic [31:0] backing_rd(input logic [31:0] a);
        int unsigned k = a >> 2;
        return backing.exists(k) ? backing[k] : dflt(k);
    endfunction

    function automatic int next_wait();
        return (bp_fixed >= 0) ? bp_fixed : int'($urandom_range(0, 2));
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
        end
    endfunction

    function automatic void model_access(input logic [31:0] addr, input bit is_store,
                                         output bit hit, output bit wb,
                                         output logic [31:0] wb_addr, output logic [31:0] f_addr);
        int set = int'(addr[9:4]);
        int way = -1;
        logic [21:0] tag = addr[31:10];
        hit = 0; wb = 0; wb_addr = '0;
        f_addr = {addr[31:4], 4'h0};
        for (int w = 0; w < WAYS; w++)
            if (way < 0 && m_valid[set][w] && m_tag[set][w] == tag) begin
                hit = 1; way = w;
            end
        if (!hit) begin
            for (int w = 0; w < WAYS; w++)
                if (way < 0 && !m_valid[set][w]) way = w;
            if (way < 0) way = m_ptr[set];
            wb      = m_valid[set][way] && m_dirty[set][way];
            wb_addr = {m_tag[set][way], addr[9:4], 4'h0};
            m_valid[set][way] = 1;
            m_dirty[set][way] = 0;
            m_tag[set][way]   = tag;
            m_ptr[set]        = (way + 1) % WAYS;
        end
        if (is_store) m_dirty[set][way] = 1;
    endfunction

    task automatic start_txn(input bit exp_wb);
        wb_cnt = 0; fetch_cnt = 0; wb_open = 0; fetch_open = 0;
        exp_wb_cur = exp_wb ? 1 : 0;
        wait_cnt = next_wait();
    endtask

    // Serve the memory side for one cycle, then advance to #1 after the next edge.
    task automatic step();
        i_line_ready = 0; i_fetch_ready = 0; i_fetch_valid = 0;
        if (o_line_valid) begin
            if (!wb_open) begin
                wb_open = 1; hold_addr = o_line_addr; hold_w1 = o_line_data[1];
            end else begin
                check_eq("wb_hold_addr", o_line_addr, hold_addr);
                check_eq("wb_hold_w1", o_line_data[1], hold_w1);
            end
            if (wait_cnt == 0) begin
                i_line_ready = 1; wb_cnt++; wb_addr_seen = o_line_addr; wb_open = 0;
                for (int w = 0; w < 4; w++) begin
                    check_eq("wb_data", o_line_data[w], shadow_rd(o_line_addr + 32'(4 * w)));
                    backing[(o_line_addr >> 2) + w] = o_line_data[w];
                end
                wait_cnt = next_wait();
            end else wait_cnt--;
        end else if (o_fetch_valid) begin
            if (!fetch_open) begin
                fetch_open = 1; hold_addr = o_fetch_addr;
                check_eq("wb_before_fetch", wb_cnt, exp_wb_cur);
            end else check_eq("fetch_hold_addr", o_fetch_addr, hold_addr);
            if (wait_cnt == 0) begin
                i_fetch_ready = 1; fetch_cnt++; fetch_addr_seen = o_fetch_addr; fetch_open = 0;
                wait_cnt = next_wait();
            end else wait_cnt--;
        end else if (o_fetch_ready) begin
            if (wait_cnt == 0) begin
                i_fetch_valid = 1;
                for (int w = 0; w < 4; w++) i_fetch_data[w] = backing_rd(fetch_addr_seen + 32'(4 * w));
                wait_cnt = next_wait();
            end else wait_cnt--;
        end
        @(posedge i_clk); #1;
    endtask

    task automatic do_load(input logic [31:0] addr);
        bit hit, wb, done, seen;
        logic [31:0] wa, fa, exp_d;
        int edges, rsp_wait, n;
        model_access(addr, 0, hit, wb, wa, fa);
        exp_d = shadow_rd(addr);
        start_txn(wb);
        i_load_addr = addr; i_load_valid = 1;
        #1;
        if (i_store_valid) check_eq("both_st_ready", o_store_ready, 0);
        n = 0;
        while (!o_load_ready && n < 100) begin @(posedge i_clk); #1; n++; end
        @(posedge i_clk); #1;
        i_load_valid = 0;
        edges = 1; done = 0; seen = 0; rsp_wait = next_wait();
        while (!done && edges < 300) begin
            if (o_load_valid) begin
                i_line_ready = 0; i_fetch_ready = 0; i_fetch_valid = 0;
                check_eq("ld_data", o_load_data, exp_d);
                if (!seen && hit) check_eq("ld_hit_lat", edges, 2);
                seen = 1;
                if (rsp_wait == 0) begin
                    i_load_ready = 1; @(posedge i_clk); #1; i_load_ready = 0; done = 1;
                end else begin
                    rsp_wait--; @(posedge i_clk); #1; edges++;
                end
            end else begin
                if (seen) check_eq("ld_valid_drop", o_load_valid, 1);
                step(); edges++;
            end
        end
        check_eq("ld_done", done, 1);
        check_eq("ld_wb_cnt", wb_cnt, exp_wb_cur);
        if (wb) check_eq("ld_wb_addr", wb_addr_seen, wa);
        check_eq("ld_fetch_cnt", fetch_cnt, hit ? 0 : 1);
        if (!hit) check_eq("ld_fetch_addr", fetch_addr_seen, fa);
        $display("LOAD  addr=%h data=%h hit=%0d wb=%0d edges=%0d", addr, o_load_data, hit, wb, edges);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit hit, wb;
        logic [31:0] wa, fa, v;
        int edges, n;
        model_access(addr, 1, hit, wb, wa, fa);
        start_txn(wb);
        i_store_addr = addr; i_store_data = data; i_store_strb = strb; i_store_valid = 1;
        #1;
        n = 0;
        while (!o_store_ready && n < 100) begin @(posedge i_clk); #1; n++; end
        @(posedge i_clk); #1;
        i_store_valid = 0;
        edges = 1;
        while (!o_load_ready && edges < 300) begin step(); edges++; end
        check_eq("st_done", o_load_ready, 1);
        if (hit) check_eq("st_hit_lat", edges, 2);
        check_eq("st_wb_cnt", wb_cnt, exp_wb_cur);
        if (wb) check_eq("st_wb_addr", wb_addr_seen, wa);
        check_eq("st_fetch_cnt", fetch_cnt, hit ? 0 : 1);
        if (!hit) check_eq("st_fetch_addr", fetch_addr_seen, fa);
        v = shadow_rd(addr);
        for (int b = 0; b < 4; b++) if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
        shadow[addr >> 2] = v;
        $display("STORE addr=%h data=%h strb=%b hit=%0d wb=%0d edges=%0d", addr, data, strb, hit, wb, edges);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_load_valid"},  o_load_valid, 0);
        check_eq({pfx, "_fetch_valid"}, o_fetch_valid, 0);
        check_eq({pfx, "_fetch_ready"}, o_fetch_ready, 0);
        check_eq({pfx, "_line_valid"},  o_line_valid, 0);
        check_eq({pfx, "_load_data"},   o_load_data, 0);
        check_eq({pfx, "_fetch_addr"},  o_fetch_addr, 0);
        check_eq({pfx, "_line_addr"},   o_line_addr, 0);
        check_eq({pfx, "_load_ready"},  o_load_ready, 1);
        check_eq({pfx, "_store_ready"}, o_store_ready, 1);
        i_load_valid = 1; #1;
        check_eq({pfx, "_store_ready_ld"}, o_store_ready, 0);
        i_load_valid = 0; #1;
    endtask

    initial begin
        logic [31:0] seed_line [4];
        logic [31:0] addr;
        int n;
        seed_line[0] = 32'h0000_5555; seed_line[1] = 32'h5555_0000;
        seed_line[2] = 32'h5555_5555; seed_line[3] = 32'h0505_0505;
        for (int w = 0; w < 4; w++) begin
            backing[(32'h1000_1000 >> 2) + w] = seed_line[w];
            shadow[(32'h1000_1000 >> 2) + w]  = seed_line[w];
        end
        model_reset();
        i_rst = 1; i_load_ready = 0; i_load_addr = 0; i_load_valid = 0;
        i_store_data = 0; i_store_strb = 0; i_store_addr = 0; i_store_valid = 0;
        i_fetch_ready = 0; i_fetch_data = '0; i_fetch_valid = 0; i_line_ready = 0;
        #3;
        check_reset_outputs("rst");
        repeat (3) @(posedge i_clk);
        #1; i_rst = 0;

        do_load(32'h1000_1000);
        do_load(32'h1000_1008);
        do_store(32'h1000_1004, 32'hAAAA_BBBB, 4'b0011);
        do_load(32'h1000_1004);
        do_load(32'h1000_2000);
        do_load(32'h1000_3000);

        bp_fixed = 5;
        do_store(32'h1000_2000, 32'hCAFE_F00D, 4'b1111);
        do_load(32'h1000_4000);
        bp_fixed = -1;

        i_store_addr = 32'h1000_3004; i_store_data = 32'h1234_5678;
        i_store_strb = 4'b1100; i_store_valid = 1;
        do_load(32'h1000_3004);
        check_eq("st_after_ld_ready", o_store_ready, 1);
        do_store(32'h1000_3004, 32'h1234_5678, 4'b1100);

        for (int t = 0; t < 150; t++) begin
            addr = 32'h1000_0000 | ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4)
                 | ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 1) == 1)
                do_load(addr);
            else
                do_store(addr, $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset while waiting for fill data on a miss into an untouched set.
        i_load_addr = 32'h2000_00A0; i_load_valid = 1;
        @(posedge i_clk); #1;
        i_load_valid = 0;
        n = 0;
        while (!o_fetch_ready && n < 100) begin
            i_line_ready = o_line_valid; i_fetch_ready = o_fetch_valid;
            @(posedge i_clk); #1; n++;
        end
        i_line_ready = 0; i_fetch_ready = 0;
        check_eq("reach_fill", o_fetch_ready, 1);
        i_rst = 1; #1;
        check_reset_outputs("fillrst");
        repeat (2) @(posedge i_clk);
        #1; i_rst = 0;
        model_reset();
        shadow.delete();
        foreach (backing[k]) shadow[k] = backing[k];
        do_load(32'h1000_1000);
        do_load(32'h1000_1008);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
